// File: rtl/adc_spi_pkg.sv
// Shared constants, state encoding and frame-load helper for the emulated
// 8-channel 12-bit serial ADC.
package adc_spi_pkg;

   localparam int DATA_W     = 12;
   localparam int NUM_CH     = 8;
   localparam int ADDR_W     = 3;
   localparam int LEAD_ZEROS = 4;
   localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
   localparam int CTRL_BITS  = 8;
   localparam int ADDR_LSB   = 3;
   localparam int ADDR_MSB   = 5;
   localparam int CNT_W      = $clog2(FRAME_BITS) + 1;

   localparam logic [CNT_W-1:0] CNT_CTRL_END = CNT_W'(CTRL_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_BITS - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic logic [FRAME_BITS-1:0] load_frame(
      input logic [NUM_CH*DATA_W-1:0] ch_data,
      input logic [ADDR_W-1:0]        sel
   );
      return {{LEAD_ZEROS{1'b0}}, ch_data[int'(sel)*DATA_W +: DATA_W]};
   endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer for one SPI pin, with registered rise/fall pulses.
// The level output is delayed one extra flop so it lines up with the pulses.
module spi_in_sync (
   input  logic clk,
   input  logic rst_l,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   // Reset to 0 so a CS_n held low across reset produces no falling edge.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
         rise <= sync & ~prev;
         fall <= ~sync & prev;
      end
   end

   assign level = prev;

endmodule

// File: rtl/adc_spi_responder.sv
// Mode-0 SPI responder emulating an 8-channel 12-bit serial ADC.
//   state    | meaning
//   ST_IDLE  | CS_n high or no frame started; MISO held 0
//   ST_SHIFT | frame active; rx on SCLK rise, tx on SCLK fall
module adc_spi_responder
   import adc_spi_pkg::*;
(
   input  logic                     i_Clk,
   input  logic                     i_Rst_L,
   input  logic [NUM_CH*DATA_W-1:0] i_Ch_Data,
   input  logic                     i_SPI_Clk,
   input  logic                     i_SPI_CS_n,
   input  logic                     i_SPI_MOSI,
   output logic                     o_SPI_MISO,
   output logic [ADDR_W-1:0]        o_Ch_Sel,
   output logic                     o_Frame_Done,
   output logic                     o_Frame_Err
);

   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic cs_rise, cs_fall, cs_level_unused;
   logic mosi, mosi_rise_unused, mosi_fall_unused;

   spi_in_sync u_sync_sclk (
      .clk   (i_Clk),
      .rst_l (i_Rst_L),
      .din   (i_SPI_Clk),
      .level (sclk_level_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_in_sync u_sync_cs (
      .clk   (i_Clk),
      .rst_l (i_Rst_L),
      .din   (i_SPI_CS_n),
      .level (cs_level_unused),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_in_sync u_sync_mosi (
      .clk   (i_Clk),
      .rst_l (i_Rst_L),
      .din   (i_SPI_MOSI),
      .level (mosi),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   state_t                  state;
   logic [CNT_W-1:0]        bit_cnt;
   logic [FRAME_BITS-1:0]   tx_sr;
   logic [CTRL_BITS-1:0]    rx_sr;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         tx_sr        <= '0;
         rx_sr        <= '0;
         o_SPI_MISO   <= 1'b0;
         o_Ch_Sel     <= '0;
         o_Frame_Done <= 1'b0;
         o_Frame_Err  <= 1'b0;
      end else begin
         o_Frame_Done <= 1'b0;
         o_Frame_Err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_SPI_MISO <= 1'b0;
               if (cs_fall) begin
                  tx_sr   <= load_frame(i_Ch_Data, o_Ch_Sel);
                  rx_sr   <= '0;
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // CS_n rise takes priority over any SCLK edge in the same cycle.
               if (cs_rise) begin
                  if (bit_cnt != '0) o_Frame_Err <= 1'b1;
                  o_SPI_MISO <= 1'b0;
                  bit_cnt    <= '0;
                  state      <= ST_IDLE;
               end else if (sclk_rise) begin
                  if (bit_cnt < CNT_CTRL_END) rx_sr <= {rx_sr[CTRL_BITS-2:0], mosi};
                  if (bit_cnt == CNT_LAST) begin
                     o_Ch_Sel     <= rx_sr[ADDR_MSB:ADDR_LSB];
                     tx_sr        <= load_frame(i_Ch_Data, rx_sr[ADDR_MSB:ADDR_LSB]);
                     o_Frame_Done <= 1'b1;
                     bit_cnt      <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (sclk_fall) begin
                  // Count 0 here means a fresh reload: present its MSB unshifted.
                  if (bit_cnt != '0) begin
                     tx_sr      <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                     o_SPI_MISO <= tx_sr[FRAME_BITS-2];
                  end else begin
                     o_SPI_MISO <= tx_sr[FRAME_BITS-1];
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: mode-0 master model, frame
// scoreboard, table-driven single frames and hand-written corner sequences.
module tb_adc_spi_responder;

   logic        i_Clk = 1'b0;
   logic        i_Rst_L;
   logic [95:0] i_Ch_Data;
   logic        i_SPI_Clk;
   logic        i_SPI_CS_n;
   logic        i_SPI_MOSI;
   logic        o_SPI_MISO;
   logic [2:0]  o_Ch_Sel;
   logic        o_Frame_Done;
   logic        o_Frame_Err;

   adc_spi_responder dut (
      .i_Clk        (i_Clk),
      .i_Rst_L      (i_Rst_L),
      .i_Ch_Data    (i_Ch_Data),
      .i_SPI_Clk    (i_SPI_Clk),
      .i_SPI_CS_n   (i_SPI_CS_n),
      .i_SPI_MOSI   (i_SPI_MOSI),
      .o_SPI_MISO   (o_SPI_MISO),
      .o_Ch_Sel     (o_Ch_Sel),
      .o_Frame_Done (o_Frame_Done),
      .o_Frame_Err  (o_Frame_Err)
   );

   always #10 i_Clk = ~i_Clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int wide_cnt = 0;
   logic prev_done = 1'b0;
   logic prev_err = 1'b0;
   logic [15:0] rx_word;
   logic [15:0] exp_q[$];

   always @(negedge i_Clk) begin
      if (o_Frame_Done === 1'b1) done_cnt++;
      if (o_Frame_Err === 1'b1) err_cnt++;
      if ((prev_done & o_Frame_Done) | (prev_err & o_Frame_Err)) wide_cnt++;
      prev_done = o_Frame_Done;
      prev_err  = o_Frame_Err;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected simulation end");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [7:0]  ctrl;
      logic [15:0] exp_word;
      logic [2:0]  exp_sel;
   } vec_t;
   vec_t vecs[7];

   task automatic tick(input int n);
      repeat (n) @(posedge i_Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_ch(input int k, input logic [11:0] v);
      i_Ch_Data[k*12 +: 12] = v;
   endtask

   task automatic shift_bits(input logic [7:0] ctrl, input int first, input int last);
      for (int i = first; i < last; i++) begin
         i_SPI_MOSI = (i < 8) ? ctrl[7-i] : 1'b0;
         tick(4);
         rx_word = {rx_word[14:0], o_SPI_MISO};
         i_SPI_Clk = 1'b1;
         tick(4);
         i_SPI_Clk = 1'b0;
      end
   endtask

   task automatic sb_compare(input string name);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got 0x%0h, expected scoreboard entry (queue empty)", name, rx_word);
      end else begin
         e = exp_q.pop_front();
         check(name, {16'h0, rx_word}, {16'h0, e});
      end
   endtask

   task automatic do_frame(input logic [7:0] ctrl, input logic [15:0] exp_word,
                           input logic [2:0] exp_sel, input bit keep_cs, input string name);
      int d0;
      d0 = done_cnt;
      if (i_SPI_CS_n) begin
         i_SPI_CS_n = 1'b0;
         tick(5);
      end
      exp_q.push_back(exp_word);
      rx_word = '0;
      shift_bits(ctrl, 0, 16);
      tick(2);
      sb_compare({name, "_miso"});
      check({name, "_sel"}, {29'h0, o_Ch_Sel}, {29'h0, exp_sel});
      check({name, "_done"}, done_cnt, d0 + 1);
      if (!keep_cs) begin
         i_SPI_CS_n = 1'b1;
         tick(6);
      end
   endtask

   initial begin
      int d0, e0;
      vecs[0] = '{8'h18, 16'h0A5C, 3'd3};
      vecs[1] = '{8'h00, 16'h03FF, 3'd0};
      vecs[2] = '{8'h38, 16'h0A5C, 3'd7};
      vecs[3] = '{8'h10, 16'h0777, 3'd2};
      vecs[4] = '{8'hC7, 16'h0222, 3'd0};
      vecs[5] = '{8'hFF, 16'h0A5C, 3'd7};
      vecs[6] = '{8'h00, 16'h0777, 3'd0};

      i_Rst_L    = 1'b0;
      i_SPI_Clk  = 1'b0;
      i_SPI_CS_n = 1'b1;
      i_SPI_MOSI = 1'b0;
      i_Ch_Data  = '0;
      set_ch(0, 12'hA5C); set_ch(1, 12'h111); set_ch(2, 12'h222); set_ch(3, 12'h3FF);
      set_ch(4, 12'h444); set_ch(5, 12'hFFF); set_ch(6, 12'h666); set_ch(7, 12'h777);

      // Reset with SCLK toggling
      for (int i = 0; i < 5; i++) begin
         tick(1);
         i_SPI_Clk = ~i_SPI_Clk;
         check("reset_outputs", {26'h0, o_SPI_MISO, o_Ch_Sel, o_Frame_Done, o_Frame_Err}, 32'h0);
      end
      i_SPI_Clk = 1'b0;
      i_Rst_L = 1'b1;
      tick(10);
      check("post_reset_no_frame", done_cnt + err_cnt, 0);
      check("post_reset_miso", {31'h0, o_SPI_MISO}, 32'h0);

      // Table-driven single frames
      for (int v = 0; v < 7; v++)
         do_frame(vecs[v].ctrl, vecs[v].exp_word, vecs[v].exp_sel, 1'b0, $sformatf("vec%0d", v));

      // Continuous mode: CS_n low across two frames
      set_ch(0, 12'h123);
      do_frame(8'h28, 16'h0123, 3'd5, 1'b1, "cont1");
      do_frame(8'h00, 16'h0FFF, 3'd0, 1'b0, "cont2");

      // Abort after 7 SCLK
      d0 = done_cnt;
      e0 = err_cnt;
      i_SPI_CS_n = 1'b0;
      tick(5);
      shift_bits(8'h38, 0, 7);
      tick(2);
      i_SPI_CS_n = 1'b1;
      tick(6);
      check("abort_err", err_cnt, e0 + 1);
      check("abort_no_done", done_cnt, d0);
      check("abort_sel", {29'h0, o_Ch_Sel}, 32'h0);
      check("abort_miso", {31'h0, o_SPI_MISO}, 32'h0);

      // Loopback: byte-wise assembly of channel 0
      set_ch(0, 12'h800);
      do_frame(8'h00, 16'h0800, 3'd0, 1'b0, "loop");
      check("loop_byte0", {24'h0, rx_word[15:8]}, 32'h08);
      check("loop_byte1", {24'h0, rx_word[7:0]}, 32'h00);

      // Channel data changed mid-frame must not affect the frame in flight
      set_ch(0, 12'h5A5);
      d0 = done_cnt;
      i_SPI_CS_n = 1'b0;
      tick(5);
      exp_q.push_back(16'h05A5);
      rx_word = '0;
      shift_bits(8'h08, 0, 6);
      set_ch(0, 12'h000);
      shift_bits(8'h08, 6, 16);
      tick(2);
      sb_compare("midchg_miso");
      check("midchg_sel", {29'h0, o_Ch_Sel}, 32'h1);
      check("midchg_done", done_cnt, d0 + 1);
      i_SPI_CS_n = 1'b1;
      tick(6);

      // Reset at SCLK 9 with CS_n held low
      set_ch(0, 12'h321);
      d0 = done_cnt;
      i_SPI_CS_n = 1'b0;
      tick(5);
      rx_word = '0;
      shift_bits(8'hFF, 0, 9);
      i_Rst_L = 1'b0;
      tick(3);
      check("midreset_outputs", {26'h0, o_SPI_MISO, o_Ch_Sel, o_Frame_Done, o_Frame_Err}, 32'h0);
      i_Rst_L = 1'b1;
      tick(3);
      rx_word = 16'hFFFF;
      shift_bits(8'h18, 0, 16);
      tick(2);
      check("midreset_no_frame_miso", {16'h0, rx_word}, 32'h0);
      check("midreset_no_done", done_cnt, d0);
      check("midreset_sel", {29'h0, o_Ch_Sel}, 32'h0);
      i_SPI_CS_n = 1'b1;
      tick(6);
      do_frame(8'h00, 16'h0321, 3'd0, 1'b0, "after_reset");

      check("pulse_width", wide_cnt, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
